// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: frame request, serial data and status signals of the shift controller
interface shift_seq_ctrl_if;
  logic       start;
  logic       abort;
  logic [7:0] din;
  logic       SI;
  logic       SO;
  logic [7:0] po;
  logic       busy;
  logic       done;
  modport master (output start, abort, din, SI, input SO, po, busy, done);
  modport slave (input start, abort, din, SI, output SO, po, busy, done);
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: 8-bit MSB-first serial shift frame controller with prescaled bit timing
module shift_seq_ctrl #(
  parameter int DIV = 4
) (
  input logic             clk,
  input logic             clr,
  shift_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state, state_nx;
  logic [7:0]  shreg, po_q;
  logic [15:0] pre;
  logic [2:0]  bitcnt;
  logic        tick, last;
  // abort outranks a coincident tick, so the tick itself is gated
  assign tick   = state == SHIFT && !bus.abort && pre == 16'(DIV - 1);
  assign last   = tick && bitcnt == 3'd7;
  assign bus.SO = shreg[7];
  assign bus.po = po_q;
  always_comb begin
    state_nx = state == IDLE  ? (bus.start ? SHIFT : IDLE)
             : state == SHIFT ? (bus.abort ? IDLE : last ? DONE : SHIFT)
             : IDLE;
    bus.busy = state == SHIFT;
    bus.done = state == DONE;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      shreg  <= '0;
      po_q   <= '0;
      pre    <= '0;
      bitcnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        shreg  <= bus.din;
        pre    <= '0;
        bitcnt <= '0;
      end else if (state == SHIFT && !bus.abort) begin
        pre <= tick ? '0 : pre + 16'd1;
        if (tick) begin
          shreg  <= {shreg[6:0], bus.SI};
          bitcnt <= bitcnt + 3'd1;
        end
        if (last) po_q <= {shreg[6:0], bus.SI};
      end
    end
  end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed frame table plus abort, restart and clear sequences on DIV=4/1/2 instances
module tb_shift_seq_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  logic       start_r[3], abort_r[3], si_r[3], loop_r[3];
  logic [7:0] din_r[3];
  logic       so_w[3], busy_w[3], done_w[3];
  logic [7:0] po_w[3];
  shift_seq_ctrl_if b0 ();
  shift_seq_ctrl_if b1 ();
  shift_seq_ctrl_if b2 ();
  shift_seq_ctrl #(.DIV(4)) u0 (.clk(clk), .clr(clr), .bus(b0.slave));
  shift_seq_ctrl #(.DIV(1)) u1 (.clk(clk), .clr(clr), .bus(b1.slave));
  shift_seq_ctrl #(.DIV(2)) u2 (.clk(clk), .clr(clr), .bus(b2.slave));
  assign b0.start = start_r[0];
  assign b0.abort = abort_r[0];
  assign b0.din   = din_r[0];
  assign b0.SI    = loop_r[0] ? b0.SO : si_r[0];
  assign b1.start = start_r[1];
  assign b1.abort = abort_r[1];
  assign b1.din   = din_r[1];
  assign b1.SI    = loop_r[1] ? b1.SO : si_r[1];
  assign b2.start = start_r[2];
  assign b2.abort = abort_r[2];
  assign b2.din   = din_r[2];
  assign b2.SI    = loop_r[2] ? b2.SO : si_r[2];
  assign so_w[0] = b0.SO;
  assign so_w[1] = b1.SO;
  assign so_w[2] = b2.SO;
  assign po_w[0] = b0.po;
  assign po_w[1] = b1.po;
  assign po_w[2] = b2.po;
  assign busy_w[0] = b0.busy;
  assign busy_w[1] = b1.busy;
  assign busy_w[2] = b2.busy;
  assign done_w[0] = b0.done;
  assign done_w[1] = b1.done;
  assign done_w[2] = b2.done;

  typedef struct {
    int         u;
    logic [7:0] din;
    logic       si;
    logic       loop;
    logic [7:0] po;
  } vec_t;
  vec_t vec[6];

  function automatic int div_of(input int u);
    return u == 0 ? 4 : u == 1 ? 1 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // entered and left on a falling edge with the instance idle
  task automatic run_frame(input int u, input logic [7:0] din, input logic si, input logic loop,
                           input logic [7:0] exp_po);
    int d = div_of(u);
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    int so_err = 0;
    din_r[u] = din;
    si_r[u] = si;
    loop_r[u] = loop;
    start_r[u] = 1'b1;
    @(negedge clk);
    start_r[u] = 1'b0;
    for (int j = 0; j < 8 * d + 3; j++) begin
      if (busy_w[u]) busy_n++;
      if (done_w[u]) begin
        done_n++;
        if (done_at < 0) done_at = j;
      end
      if (j < 8 * d && so_w[u] !== din[7 - j / d]) so_err++;
      @(negedge clk);
    end
    chk($sformatf("busy_cycles u%0d din=%h", u, din), busy_n, 8 * d);
    chk($sformatf("done_count u%0d din=%h", u, din), done_n, 1);
    chk($sformatf("done_time u%0d din=%h", u, din), done_at, 8 * d);
    chk($sformatf("so_seq_errors u%0d din=%h", u, din), so_err, 0);
    chk($sformatf("po u%0d din=%h", u, din), po_w[u], exp_po);
    chk($sformatf("so_idle u%0d din=%h", u, din), so_w[u], exp_po[7]);
  endtask

  initial begin
    int seen;
    vec[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5};
    vec[1] = '{0, 8'h00, 1'b1, 1'b0, 8'hFF};
    vec[2] = '{0, 8'hC3, 1'b0, 1'b0, 8'h00};
    vec[3] = '{0, 8'h5A, 1'b1, 1'b1, 8'h5A};
    vec[4] = '{1, 8'h96, 1'b1, 1'b0, 8'hFF};
    vec[5] = '{2, 8'h69, 1'b0, 1'b1, 8'h69};
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0;
      abort_r[i] = 1'b0;
      si_r[i] = 1'b0;
      loop_r[i] = 1'b0;
      din_r[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_so u%0d", i), so_w[i], 0);
      chk($sformatf("reset_po u%0d", i), po_w[i], 0);
      chk($sformatf("reset_busy u%0d", i), busy_w[i], 0);
      chk($sformatf("reset_done u%0d", i), done_w[i], 0);
    end
    clr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_frame(vec[i].u, vec[i].din, vec[i].si, vec[i].loop, vec[i].po);

    // DIV=1: start during DONE is dropped, start on the following idle cycle runs
    din_r[1] = 8'h3C;
    si_r[1] = 1'b0;
    loop_r[1] = 1'b0;
    start_r[1] = 1'b1;
    @(negedge clk);
    start_r[1] = 1'b0;
    repeat (8) @(negedge clk);
    chk("div1_done_at_8", done_w[1], 1);
    chk("div1_po_first", po_w[1], 8'h00);
    start_r[1] = 1'b1;
    din_r[1] = 8'hFF;
    si_r[1] = 1'b1;
    @(negedge clk);
    chk("div1_start_in_done_ignored", busy_w[1], 0);
    chk("div1_done_one_cycle", done_w[1], 0);
    @(negedge clk);
    start_r[1] = 1'b0;
    chk("div1_restart_busy", busy_w[1], 1);
    repeat (8) @(negedge clk);
    chk("div1_second_done", done_w[1], 1);
    chk("div1_po_second", po_w[1], 8'hFF);
    @(negedge clk);

    // DIV=4: start repeated mid-frame, abort on the fourth tick
    din_r[0] = 8'h10;
    si_r[0] = 1'b0;
    loop_r[0] = 1'b0;
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    seen = 0;
    for (int j = 0; j < 16; j++) begin
      if (done_w[0]) seen++;
      if (j == 9) start_r[0] = 1'b1;
      if (j == 10) begin
        start_r[0] = 1'b0;
        chk("abort_busy_mid_frame", busy_w[0], 1);
      end
      if (j == 15) abort_r[0] = 1'b1;
      @(negedge clk);
    end
    abort_r[0] = 1'b0;
    chk("abort_idle_busy", busy_w[0], 0);
    chk("abort_no_shift_so", so_w[0], 1);
    chk("abort_po_kept", po_w[0], 8'h5A);
    for (int j = 0; j < 4; j++) begin
      if (done_w[0] || busy_w[0]) seen++;
      @(negedge clk);
    end
    chk("abort_no_done_no_frame", seen, 0);
    abort_r[0] = 1'b1;
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    chk("abort_in_idle_no_effect", busy_w[0], 1);
    @(negedge clk);
    abort_r[0] = 1'b0;
    chk("abort_in_shift_busy", busy_w[0], 0);
    chk("abort_in_shift_done", done_w[0], 0);

    // DIV=2: clear mid-frame, start while cleared, then a clean frame
    din_r[2] = 8'hFF;
    si_r[2] = 1'b1;
    loop_r[2] = 1'b0;
    start_r[2] = 1'b1;
    @(negedge clk);
    start_r[2] = 1'b0;
    seen = 0;
    for (int j = 0; j < 7; j++) begin
      if (done_w[2]) seen++;
      @(negedge clk);
    end
    chk("clr_pre_so", so_w[2], 1);
    chk("clr_pre_busy", busy_w[2], 1);
    #2 clr = 1'b1;
    #1;
    chk("clr_async_so", so_w[2], 0);
    chk("clr_async_po", po_w[2], 0);
    chk("clr_async_busy", busy_w[2], 0);
    chk("clr_async_done", done_w[2], 0);
    chk("clr_async_po_u0", po_w[0], 0);
    start_r[2] = 1'b1;
    @(negedge clk);
    if (done_w[2]) seen++;
    chk("clr_start_ignored", busy_w[2], 0);
    start_r[2] = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    if (done_w[2]) seen++;
    chk("clr_no_done", seen, 0);
    run_frame(2, 8'hC5, 1'b0, 1'b1, 8'hC5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
